// File: rtl/branch_predict_btb.sv
// Tagged branch target buffer: combinational fetch lookup, per-entry saturating
// direction counters, allocate-on-taken updates and a single-cycle bulk flush.

module btb_entry #(
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                sel,
    input  logic                upd_taken,
    input  logic [TAG_BITS-1:0] upd_tag,
    input  logic [31:0]         upd_target,
    output logic                valid,
    output logic [TAG_BITS-1:0] tag,
    output logic [31:0]         target,
    output logic [CTR_BITS-1:0] ctr
);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));

    logic uh;
    assign uh = valid && (tag == upd_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            tag    <= '0;
            target <= '0;
            ctr    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (sel) begin
            if (uh) begin
                if (upd_taken) begin
                    target <= upd_target;
                    if (ctr != CTR_MAX) ctr <= ctr + 1'b1;
                end else if (ctr != '0) begin
                    ctr <= ctr - 1'b1;
                end
            end else if (upd_taken) begin
                // Miss on a taken branch replaces whatever lives at this index.
                valid  <= 1'b1;
                tag    <= upd_tag;
                target <= upd_target;
                ctr    <= CTR_INIT;
            end
        end
    end
endmodule

module branch_predict_btb #(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic [31:0] PC_pred,
    output logic        pred_taken,
    output logic        hit,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic [ENTRIES-1:0]               valid_q;
    logic [ENTRIES-1:0][TAG_BITS-1:0] tag_q;
    logic [ENTRIES-1:0][31:0]         target_q;
    logic [ENTRIES-1:0][CTR_BITS-1:0] ctr_q;

    logic [INDEX_BITS-1:0] lk_idx, upd_idx;
    logic [TAG_BITS-1:0]   lk_tag, upd_tag;

    assign lk_idx  = PC[TAG_LO-1:2];
    assign lk_tag  = PC[TAG_HI:TAG_LO];
    assign upd_idx = upd_pc[TAG_LO-1:2];
    assign upd_tag = upd_pc[TAG_HI:TAG_LO];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        btb_entry #(
            .TAG_BITS (TAG_BITS),
            .CTR_BITS (CTR_BITS)
        ) u_entry (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .sel        (upd_valid && (upd_idx == INDEX_BITS'(i))),
            .upd_taken  (upd_taken),
            .upd_tag    (upd_tag),
            .upd_target (upd_target),
            .valid      (valid_q[i]),
            .tag        (tag_q[i]),
            .target     (target_q[i]),
            .ctr        (ctr_q[i])
        );
    end

    // Read side sees registered state only: same-cycle updates show up next cycle.
    always_comb begin
        hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        PC_pred    = hit ? target_q[lk_idx] : 32'h0;
        pred_taken = hit && ctr_q[lk_idx][CTR_BITS-1];
    end

    // Byte-offset bits and bits above the tag take no part in lookup.
    logic unused_bits;
    if (TAG_HI < 31) begin : g_hi_unused
        assign unused_bits = ^{PC[1:0], upd_pc[1:0], PC[31:TAG_HI+1], upd_pc[31:TAG_HI+1]};
    end else begin : g_no_hi
        assign unused_bits = ^{PC[1:0], upd_pc[1:0]};
    end
endmodule

// File: tb/tb_branch_predict_btb.sv
// Scenario bench for branch_predict_btb: each step drives a lookup (plus optional
// update/flush), queues the expected lookup result and compares it before the edge.

module tb_branch_predict_btb;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic [31:0] PC_pred;
    logic        pred_taken;
    logic        hit;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        upd;
        logic [31:0] upd_pc;
        logic        tk;
        logic [31:0] tgt;
        logic        fl;
        logic [31:0] look;
        logic        eh;
        logic        et;
        logic [31:0] ep;
    } step_t;

    step_t sb[$];

    branch_predict_btb #(.INDEX_BITS(7), .TAG_BITS(8), .CTR_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .PC         (PC),
        .PC_pred    (PC_pred),
        .pred_taken (pred_taken),
        .hit        (hit),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    task automatic drive(input step_t s);
        PC         = s.look;
        upd_valid  = s.upd;
        upd_pc     = s.upd_pc;
        upd_taken  = s.tk;
        upd_target = s.tgt;
        flush      = s.fl;
        sb.push_back(s);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        step_t e;
        // Still inside reset, before any clock edge.
        #3;
        sb.push_back('{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0});
        e = sb.pop_front();
        checks++;
        if ({hit, pred_taken, PC_pred} !== {e.eh, e.et, e.ep}) begin
            failures++;
            $display("FAIL reset_in got hit=%0b taken=%0b pred=%h want %0b %0b %h", hit, pred_taken, PC_pred, e.eh, e.et, e.ep);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        sb.push_back('{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0});
        e = sb.pop_front();
        checks++;
        if ({hit, pred_taken, PC_pred} !== {e.eh, e.et, e.ep}) begin
            failures++;
            $display("FAIL reset_out got hit=%0b taken=%0b pred=%h want %0b %0b %h", hit, pred_taken, PC_pred, e.eh, e.et, e.ep);
        end
        advance();
    endtask

    task automatic test_alloc_saturate();
        step_t s[$];
        step_t e;
        s.push_back('{1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0});
        s.push_back('{1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 1'b1, 32'h100});
        s.push_back('{1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 1'b1, 32'h100});
        s.push_back('{1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h40, 1'b1, 1'b1, 32'h100});
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sb.pop_front();
            checks++;
            if ({hit, pred_taken, PC_pred} !== {e.eh, e.et, e.ep}) begin
                failures++;
                $display("FAIL alloc[%0d] got hit=%0b taken=%0b pred=%h want %0b %0b %h", i, hit, pred_taken, PC_pred, e.eh, e.et, e.ep);
            end
            advance();
        end
    endtask

    task automatic test_decrement();
        step_t s[$];
        step_t e;
        s.push_back('{1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 32'h40, 1'b1, 1'b1, 32'h100});
        s.push_back('{1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 32'h40, 1'b1, 1'b1, 32'h100});
        s.push_back('{1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 32'h40, 1'b1, 1'b0, 32'h100});
        s.push_back('{1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 32'h40, 1'b1, 1'b0, 32'h100});
        s.push_back('{1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 1'b0, 32'h100});
        s.push_back('{1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h40, 1'b1, 1'b0, 32'h100});
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sb.pop_front();
            checks++;
            if ({hit, pred_taken, PC_pred} !== {e.eh, e.et, e.ep}) begin
                failures++;
                $display("FAIL decrement[%0d] got hit=%0b taken=%0b pred=%h want %0b %0b %h", i, hit, pred_taken, PC_pred, e.eh, e.et, e.ep);
            end
            advance();
        end
    endtask

    task automatic test_alias();
        step_t s[$];
        step_t e;
        s.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h40,  1'b1, 1'b0, 32'h100});
        s.push_back('{1'b1, 32'h40,  1'b1, 32'h100, 1'b0, 32'h40,  1'b0, 1'b0, 32'h0});
        s.push_back('{1'b1, 32'h240, 1'b1, 32'h300, 1'b0, 32'h240, 1'b0, 1'b0, 32'h0});
        s.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h40,  1'b0, 1'b0, 32'h0});
        s.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h240, 1'b1, 1'b1, 32'h300});
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sb.pop_front();
            checks++;
            if ({hit, pred_taken, PC_pred} !== {e.eh, e.et, e.ep}) begin
                failures++;
                $display("FAIL alias[%0d] got hit=%0b taken=%0b pred=%h want %0b %0b %h", i, hit, pred_taken, PC_pred, e.eh, e.et, e.ep);
            end
            advance();
        end
    endtask

    task automatic test_flush();
        step_t s[$];
        step_t e;
        s.push_back('{1'b1, 32'h80, 1'b0, 32'h0,   1'b0, 32'h80,  1'b0, 1'b0, 32'h0});
        s.push_back('{1'b1, 32'h84, 1'b1, 32'h500, 1'b1, 32'h80,  1'b0, 1'b0, 32'h0});
        s.push_back('{1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h84,  1'b0, 1'b0, 32'h0});
        s.push_back('{1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h240, 1'b0, 1'b0, 32'h0});
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sb.pop_front();
            checks++;
            if ({hit, pred_taken, PC_pred} !== {e.eh, e.et, e.ep}) begin
                failures++;
                $display("FAIL flush[%0d] got hit=%0b taken=%0b pred=%h want %0b %0b %h", i, hit, pred_taken, PC_pred, e.eh, e.et, e.ep);
            end
            advance();
        end
    endtask

    task automatic test_ignored_bits();
        step_t s[$];
        step_t e;
        s.push_back('{1'b1, 32'h83, 1'b1, 32'h600, 1'b0, 32'h80,       1'b0, 1'b0, 32'h0});
        s.push_back('{1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h80,       1'b1, 1'b1, 32'h600});
        s.push_back('{1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0002_0083, 1'b1, 1'b1, 32'h600});
        s.push_back('{1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h280,      1'b0, 1'b0, 32'h0});
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sb.pop_front();
            checks++;
            if ({hit, pred_taken, PC_pred} !== {e.eh, e.et, e.ep}) begin
                failures++;
                $display("FAIL ignored_bits[%0d] got hit=%0b taken=%0b pred=%h want %0b %0b %h", i, hit, pred_taken, PC_pred, e.eh, e.et, e.ep);
            end
            advance();
        end
    endtask

    task automatic test_same_cycle();
        step_t s[$];
        step_t e;
        s.push_back('{1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0});
        s.push_back('{1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h40, 1'b1, 1'b1, 32'h100});
        s.push_back('{1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h40, 1'b1, 1'b1, 32'h200});
        foreach (s[i]) begin
            drive(s[i]);
            #2;
            e = sb.pop_front();
            checks++;
            if ({hit, pred_taken, PC_pred} !== {e.eh, e.et, e.ep}) begin
                failures++;
                $display("FAIL same_cycle[%0d] got hit=%0b taken=%0b pred=%h want %0b %0b %h", i, hit, pred_taken, PC_pred, e.eh, e.et, e.ep);
            end
            advance();
        end
    endtask

    task automatic test_rst_mid();
        step_t s[3];
        step_t e;
        // Entry 0x40 holds 0x200 here; reset lands mid-cycle, clock held low.
        s[0] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h40, 1'b1, 1'b1, 32'h200};
        s[1] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0};
        s[2] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h80, 1'b0, 1'b0, 32'h0};
        foreach (s[i]) begin
            drive(s[i]);
            if (i == 1) rst = 1'b1;
            #1;
            e = sb.pop_front();
            checks++;
            if ({hit, pred_taken, PC_pred} !== {e.eh, e.et, e.ep}) begin
                failures++;
                $display("FAIL rst_mid[%0d] got hit=%0b taken=%0b pred=%h want %0b %0b %h", i, hit, pred_taken, PC_pred, e.eh, e.et, e.ep);
            end
        end
        rst = 1'b0;
        advance();
    endtask

    initial begin
        rst        = 1'b1;
        PC         = 32'h40;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        flush      = 1'b0;
        test_reset();
        test_alloc_saturate();
        test_decrement();
        test_alias();
        test_flush();
        test_ignored_bits();
        test_same_cycle();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predict_btb.md
Name: branch_predict_btb

Overview:
- Tagged, parametrised branch target buffer with per-entry N-bit saturating direction counters.
- Fetch-stage lookup is combinational on PC. It returns a predicted target and a taken flag only on a tag hit.
- Decode/resolve stage drives an explicit update port carrying the PC of the resolved branch, its outcome and its target.
- Successor to the untagged 2-bit local predictor. Adds tags, valid bits, configurable depth and counter width, allocate-on-taken and a bulk flush.

Parameters:
- INDEX_BITS, 7, log2 of entry count (128 entries). Index = PC[INDEX_BITS+1:2].
- TAG_BITS, 8, tag width. Tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]. Constraint: INDEX_BITS+TAG_BITS <= 30.
- CTR_BITS, 2, direction counter width, >= 1. Predict taken when counter MSB = 1.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- PC  input  32  fetch PC to look up
- PC_pred  output  32  predicted target; 0 on miss
- pred_taken  output  1  hit AND counter MSB
- hit  output  1  valid entry with matching tag at PC's index
- upd_valid  input  1  update request this cycle
- upd_pc  input  32  PC of resolved branch
- upd_taken  input  1  resolved direction
- upd_target  input  32  resolved target (meaningful when upd_taken=1)
- flush  input  1  invalidate all entries

Behaviour:
- Storage per entry: valid, tag[TAG_BITS], target[32], ctr[CTR_BITS].
- Reset (async, rst=1): all valid=0, tags=0, targets=0, ctr=0. Outputs are hit=0, pred_taken=0, PC_pred=0 while in reset and until the first allocation.
- Lookup is purely combinational, zero latency. hit = valid[idx] && tag[idx]==PC tag. PC_pred = hit ? target : 0. pred_taken = hit && ctr[CTR_BITS-1].
- Update on posedge with upd_valid=1 and flush=0. Let u = index of upd_pc and uh = upd_pc tag matches the valid entry at u.
- uh=1, upd_taken=1: ctr = min(ctr+1, 2^CTR_BITS-1); target <= upd_target.
- uh=1, upd_taken=0: ctr = max(ctr-1, 0); target unchanged; entry stays valid.
- uh=0, upd_taken=1: allocate by overwriting entry u (replace any conflicting tag). Set valid=1, tag, target, ctr = 2^(CTR_BITS-1) (weakly taken).
- uh=0, upd_taken=0: no state change (no allocation on not-taken).
- Flush at posedge: all valid bits cleared in one cycle. Tags, targets and counters are don't-care afterwards. An upd_valid in the same cycle is dropped; flush wins.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. There is no write-to-read bypass; the new value is visible the cycle after the edge.
- upd_pc[1:0] and PC[1:0] are ignored. Bits above the tag are ignored, so aliasing is permitted.
- rst asserted mid-operation clears state immediately, regardless of clk, upd_valid or flush.
- CTR_BITS=1: counter acts as a last-outcome bit. Allocation sets ctr=1.
- No stall input. The producer must hold upd_valid low for squashed or stalled branches; each upd_valid=1 cycle is exactly one update.

Test Plan (defaults INDEX_BITS=7, TAG_BITS=8, CTR_BITS=2):
- Reset, then lookup PC=0x0000_0040 -> hit=0, pred_taken=0, PC_pred=0.
- Update upd_pc=0x40, taken, target=0x100. Next cycle lookup PC=0x40 -> hit=1, pred_taken=1, PC_pred=0x100 (ctr=2). Two more taken updates -> ctr saturates at 3.
- From ctr=3 apply three not-taken updates -> ctr 2,1,0. pred_taken=1 after the first update, 0 after the second, 0 after the third; hit stays 1 and PC_pred stays 0x100.
- Aliasing: allocate 0x40 (taken, target 0x100), then lookup 0x40+0x200 (same index, different tag) -> hit=0. Taken update at 0x240 with target 0x300 -> lookup 0x40 now misses; lookup 0x240 hits with target 0x300.
- Not-taken update to a missing PC 0x80 -> lookup 0x80 still hit=0. Flush with upd_valid=1 (taken, PC 0x84) in the same cycle -> all lookups miss, including 0x84.
- Same-cycle lookup and update at PC 0x40 with target 0x200 on a hit entry holding 0x100 -> PC_pred=0x100 that cycle, 0x200 the next. Assert rst mid-sequence -> outputs drop to 0 without waiting for a clock edge.
